ex_muldiv_ctrl: RTL and testbench
=================================

# ex_muldiv_ctrl

Multiply/divide sequencer for the EX stage of the five-stage MIPS pipeline. It decodes the EX-stage instruction, launches mult/multu/div/divu on the rs/rt operands, and models multi-cycle latency with a down-counter. It owns the HI/LO architectural registers, serves mfhi/mflo reads, and exports busy/start so the hazard unit can stall later multiply/divide-class instructions in D.

## Interface
- MULT_CYCLES, 5, cycles `busy` stays high after a mult/multu launch (1..15)
- DIV_CYCLES, 10, cycles `busy` stays high after a div/divu launch (1..15)

- clk  input  1  pipeline clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- Inst  input  32  instruction currently in EX (already flushed to 0 on bubble)
- A  input  32  forwarded rs value in EX
- B  input  32  forwarded rt value in EX
- start  output  1  combinational: Inst is mult/multu/div/divu and state is IDLE
- busy  output  1  registered: operation in flight
- HI  output  32  architectural HI
- LO  output  32  architectural LO
- MD_out  output  32  combinational: HI if Inst is mfhi, LO if mflo, else 0

## Operation
- Decode requires opcode 000000. funct: mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mthi 010001, mflo 010010, mtlo 010011.
- States: IDLE, BUSY. Internal: 4-bit cnt, 32-bit pend_hi and pend_lo.
- IDLE + start: compute the result from A and B. Load pend_hi/pend_lo. Load cnt with MULT_CYCLES or DIV_CYCLES. Go to BUSY.
- BUSY: decrement cnt each edge. On the edge where cnt==1, copy pend_hi→HI and pend_lo→LO, then go to IDLE.
- mult: {HI,LO} = signed A × signed B, 64-bit. multu: same, unsigned.
- div: LO = signed quotient truncated toward zero; HI = remainder, with the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned quotient and remainder.
- Divide by zero: launch and busy proceed normally, but HI/LO are left unchanged at completion.
- mthi/mtlo in IDLE: HI (or LO) ← A on the edge ending the EX cycle.
- MD-class instruction in EX while BUSY (mult/div/mthi/mtlo): protocol violation, ignored. The hazard unit must stall such instructions in D while start|busy. mfhi/mflo likewise must not reach EX while busy.
- Reset values: state IDLE, cnt 0, HI 0, LO 0, pend_hi 0, pend_lo 0, busy 0. start and MD_out follow the combinational rules.

## Timing
- Launch edge E0 (start=1 during the preceding cycle) → busy=1 from E0 through edge E(N−1). At edge EN, busy falls and HI/LO update together. N = MULT_CYCLES or DIV_CYCLES.
- HI/LO never change mid-operation. A read in the cycle after busy falls returns the new values.
- The instruction after a launch may enter EX at E0. Non-MD instructions flow normally during BUSY.
- A new launch can be accepted in the first cycle after busy falls: back-to-back spacing is N+1 cycles minimum.
- Reset asserted mid-operation: abort immediately, discard pending results, HI/LO=0. Normal operation resumes on the first edge after deassertion.
- start and MD_out are purely combinational from Inst, state, HI and LO. There is no same-cycle dependence on busy-falling writes.

## Test plan
- Reset, then multu A=0xFFFFFFFF, B=2 → busy high 5 cycles; HI=0x00000001, LO=0xFFFFFFFE; mflo then reads 0xFFFFFFFE.
- mult A=0xFFFFFFFD (−3), B=7 → after 5 cycles HI=0xFFFFFFFF, LO=0xFFFFFFEB; HI/LO must hold their old values on every busy cycle.
- div A=0xFFFFFFF9 (−7), B=2 → busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu with the same operands → LO=0x7FFFFFFC, HI=1.
- mthi A=0x12345678, then divu B=0 → after 10 cycles busy=0 and HI remains 0x12345678.
- div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0. A second mult issued while busy → ignored; only the first result commits.
- Reset pulse at cycle 3 of a div → busy=0 and HI=LO=0 asynchronously; a fresh mult after deassertion completes in exactly 5 cycles.

Source files
------------

// File: rtl/ex_muldiv_ctrl_if.sv
// Multiply/divide sequencer bus: EX-stage instruction and operands in;
// start, busy, HI/LO and the mfhi/mflo read value out.
//   master : drives Inst, A, B; observes start, busy, HI, LO, MD_out
//   slave  : the sequencer itself
interface ex_muldiv_ctrl_if;
    logic [31:0] Inst;
    logic [31:0] A;
    logic [31:0] B;
    logic        start;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MD_out;

    modport master (
        output Inst, A, B,
        input  start, busy, HI, LO, MD_out
    );

    modport slave (
        input  Inst, A, B,
        output start, busy, HI, LO, MD_out
    );
endinterface

// File: rtl/ex_muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer for the EX stage; owns HI/LO.
// Ports: clk, reset (async, active-high), md (slave: Inst/A/B in,
// start/busy/HI/LO/MD_out out).
module ex_muldiv_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic           clk,
    input  logic           reset,
    ex_muldiv_ctrl_if.slave md
);

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;

    logic        is_r;
    logic [5:0]  funct;
    logic        is_mult, is_multu, is_div, is_divu;
    logic        is_mfhi, is_mflo, is_mthi, is_mtlo;
    logic        is_launch;
    logic        unused_bits;

    logic [63:0] prod_s, prod_u;
    logic [31:0] abs_a, abs_b, dvs_s, q_mag, r_mag;
    logic [31:0] q_s, r_s, dvs_u, q_u, r_u;
    logic [31:0] res_hi, res_lo;

    assign is_r  = (md.Inst[31:26] == 6'b000000);
    assign funct = md.Inst[5:0];

    assign is_mult  = is_r && (funct == F_MULT);
    assign is_multu = is_r && (funct == F_MULTU);
    assign is_div   = is_r && (funct == F_DIV);
    assign is_divu  = is_r && (funct == F_DIVU);
    assign is_mfhi  = is_r && (funct == F_MFHI);
    assign is_mflo  = is_r && (funct == F_MFLO);
    assign is_mthi  = is_r && (funct == F_MTHI);
    assign is_mtlo  = is_r && (funct == F_MTLO);

    assign is_launch = is_mult | is_multu | is_div | is_divu;

    // Register fields are irrelevant to this decode.
    assign unused_bits = ^md.Inst[25:6];

    // Arithmetic datapath. Signed divide works on magnitudes so that
    // 0x80000000 / -1 falls out as 0x80000000 rem 0 with no overflow
    // special case. A zero divisor is replaced by 1 only to keep the
    // dividers defined; that result is never committed.
    always_comb begin
        prod_s = 64'($signed({{32{md.A[31]}}, md.A})
                   * $signed({{32{md.B[31]}}, md.B}));
        prod_u = {32'b0, md.A} * {32'b0, md.B};

        abs_a = md.A[31] ? (32'd0 - md.A) : md.A;
        abs_b = md.B[31] ? (32'd0 - md.B) : md.B;
        dvs_s = (md.B == 32'd0) ? 32'd1 : abs_b;
        q_mag = abs_a / dvs_s;
        r_mag = abs_a % dvs_s;
        q_s   = (md.A[31] ^ md.B[31]) ? (32'd0 - q_mag) : q_mag;
        r_s   = md.A[31] ? (32'd0 - r_mag) : r_mag;

        dvs_u = (md.B == 32'd0) ? 32'd1 : md.B;
        q_u   = md.A / dvs_u;
        r_u   = md.A % dvs_u;

        res_hi = hi_q;
        res_lo = lo_q;
        unique case (1'b1)
            is_mult: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            is_multu: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            is_div: begin
                if (md.B != 32'd0) begin
                    res_hi = r_s;
                    res_lo = q_s;
                end
            end
            is_divu: begin
                if (md.B != 32'd0) begin
                    res_hi = r_u;
                    res_lo = q_u;
                end
            end
            default: ;
        endcase
    end

    // Next state. HI/LO cannot change while BUSY, so a zero-divisor
    // launch simply captures the current HI/LO as its pending result.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;

        unique case (state_q)
            IDLE: begin
                if (is_launch) begin
                    pend_hi_d = res_hi;
                    pend_lo_d = res_lo;
                    cnt_d     = (is_div | is_divu) ? DIV_N : MULT_N;
                    state_d   = BUSY;
                end else if (is_mthi) begin
                    hi_d = md.A;
                end else if (is_mtlo) begin
                    lo_d = md.A;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd1) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    assign md.start  = is_launch && (state_q == IDLE);
    assign md.busy   = (state_q == BUSY);
    assign md.HI     = hi_q;
    assign md.LO     = lo_q;
    assign md.MD_out = is_mfhi ? hi_q : (is_mflo ? lo_q : 32'd0);

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Testbench for ex_muldiv_ctrl: table of MD operations with
// hand-computed HI/LO plus hand sequences for busy-time and reset cases.
module tb_ex_muldiv_ctrl;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef struct {
        logic [5:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    ex_muldiv_ctrl_if md_if ();

    ex_muldiv_ctrl #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .md   (md_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] r_inst(input logic [5:0] f);
        return {26'b0, f};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t        tv[10];
    logic [31:0] prev_hi, prev_lo;
    int          cyc;

    initial begin
        checks = 0;
        errors = 0;

        tv[0] = '{F_MULTU, 32'hFFFFFFFF, 32'h2,
                  32'h00000001, 32'hFFFFFFFE, 5};
        tv[1] = '{F_MULT,  32'hFFFFFFFD, 32'h7,
                  32'hFFFFFFFF, 32'hFFFFFFEB, 5};
        tv[2] = '{F_DIV,   32'hFFFFFFF9, 32'h2,
                  32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        tv[3] = '{F_DIVU,  32'hFFFFFFF9, 32'h2,
                  32'h00000001, 32'h7FFFFFFC, 10};
        tv[4] = '{F_MTHI,  32'h12345678, 32'h0,
                  32'h12345678, 32'h7FFFFFFC, 0};
        tv[5] = '{F_DIVU,  32'h00000005, 32'h0,
                  32'h12345678, 32'h7FFFFFFC, 10};
        tv[6] = '{F_DIV,   32'h80000000, 32'hFFFFFFFF,
                  32'h00000000, 32'h80000000, 10};
        tv[7] = '{F_MTLO,  32'hCAFEF00D, 32'h0,
                  32'h00000000, 32'hCAFEF00D, 0};
        tv[8] = '{F_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF,
                  32'h3FFFFFFF, 32'h00000001, 5};
        tv[9] = '{F_DIV,   32'h00000007, 32'hFFFFFFFE,
                  32'h00000001, 32'hFFFFFFFD, 10};

        reset      = 1'b1;
        md_if.Inst = 32'd0;
        md_if.A    = 32'd0;
        md_if.B    = 32'd0;
        #12;
        chk("rst_busy", {31'd0, md_if.busy}, 32'd0);
        chk("rst_hi", md_if.HI, 32'd0);
        chk("rst_lo", md_if.LO, 32'd0);
        chk("rst_start", {31'd0, md_if.start}, 32'd0);
        md_if.Inst = r_inst(F_MFHI);
        #1;
        chk("rst_mdout", md_if.MD_out, 32'd0);
        md_if.Inst = 32'd0;
        tick();
        reset   = 1'b0;
        prev_hi = 32'd0;
        prev_lo = 32'd0;

        for (int i = 0; i < 10; i++) begin
            md_if.Inst = r_inst(tv[i].funct);
            md_if.A    = tv[i].a;
            md_if.B    = tv[i].b;
            #1;
            chk($sformatf("v%0d_start", i), {31'd0, md_if.start},
                {31'd0, tv[i].n > 0});
            chk($sformatf("v%0d_mdout0", i), md_if.MD_out, 32'd0);
            tick();
            md_if.Inst = 32'd0;
            md_if.A    = 32'd0;
            md_if.B    = 32'd0;
            for (int k = 0; k < tv[i].n; k++) begin
                chk($sformatf("v%0d_busy_c%0d", i, k),
                    {31'd0, md_if.busy}, 32'd1);
                chk($sformatf("v%0d_hold_hi_c%0d", i, k),
                    md_if.HI, prev_hi);
                chk($sformatf("v%0d_hold_lo_c%0d", i, k),
                    md_if.LO, prev_lo);
                tick();
            end
            chk($sformatf("v%0d_busy_end", i), {31'd0, md_if.busy}, 32'd0);
            chk($sformatf("v%0d_hi", i), md_if.HI, tv[i].hi);
            chk($sformatf("v%0d_lo", i), md_if.LO, tv[i].lo);
            md_if.Inst = r_inst(F_MFLO);
            #1;
            chk($sformatf("v%0d_mflo", i), md_if.MD_out, tv[i].lo);
            md_if.Inst = r_inst(F_MFHI);
            #1;
            chk($sformatf("v%0d_mfhi", i), md_if.MD_out, tv[i].hi);
            md_if.Inst = 32'd0;
            prev_hi = tv[i].hi;
            prev_lo = tv[i].lo;
        end

        // MD instructions reaching EX while busy are ignored.
        md_if.Inst = r_inst(F_DIV);
        md_if.A    = 32'd100;
        md_if.B    = 32'd7;
        #1;
        chk("ovr_start", {31'd0, md_if.start}, 32'd1);
        tick();
        md_if.Inst = r_inst(F_MULT);
        md_if.A    = 32'd3;
        md_if.B    = 32'd5;
        #1;
        chk("ovr_start_busy", {31'd0, md_if.start}, 32'd0);
        tick();
        md_if.Inst = r_inst(F_MTHI);
        md_if.A    = 32'h0000FFFF;
        tick();
        md_if.Inst = 32'd0;
        md_if.A    = 32'd0;
        md_if.B    = 32'd0;
        for (int k = 2; k < 10; k++) begin
            chk($sformatf("ovr_busy_c%0d", k), {31'd0, md_if.busy}, 32'd1);
            chk($sformatf("ovr_hold_hi_c%0d", k), md_if.HI, prev_hi);
            tick();
        end
        chk("ovr_busy_end", {31'd0, md_if.busy}, 32'd0);
        chk("ovr_hi", md_if.HI, 32'd2);
        chk("ovr_lo", md_if.LO, 32'd14);

        // Asynchronous reset in the middle of a divide.
        md_if.Inst = r_inst(F_DIV);
        md_if.A    = 32'hFFFFFFF9;
        md_if.B    = 32'd2;
        #1;
        tick();
        md_if.Inst = 32'd0;
        tick();
        tick();
        chk("ar_busy_pre", {31'd0, md_if.busy}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_busy", {31'd0, md_if.busy}, 32'd0);
        chk("ar_hi", md_if.HI, 32'd0);
        chk("ar_lo", md_if.LO, 32'd0);
        tick();
        reset = 1'b0;
        chk("ar_busy_held", {31'd0, md_if.busy}, 32'd0);
        md_if.Inst = r_inst(F_MULT);
        md_if.A    = 32'd6;
        md_if.B    = 32'd7;
        #1;
        chk("ar_start", {31'd0, md_if.start}, 32'd1);
        tick();
        md_if.Inst = 32'd0;
        cyc = 0;
        while (md_if.busy && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("ar_mult_cycles", 32'(cyc), 32'd5);
        chk("ar_mult_hi", md_if.HI, 32'd0);
        chk("ar_mult_lo", md_if.LO, 32'd42);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
